// File: rtl/operand_sequencer_if.sv
// Operand/result bundle between a feeder, the sequencer and the adder.
// Ports: operand beats, adder bus, result handshake; res_ovf if OPSEQ_OVF_DETECT_EN.
interface operand_sequencer_if #(
  parameter int SIZE = 16
);
  logic [SIZE-1:0] in_data;
  logic            in_cin;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] op_a;
  logic [SIZE-1:0] op_b;
  logic            op_cin;
  logic            op_en;
  logic [SIZE-1:0] sum_in;
  logic            cout_in;
  logic [SIZE-1:0] res;
  logic            res_cout;
  logic            res_valid;
  logic            res_ready;
`ifdef OPSEQ_OVF_DETECT_EN
  logic            res_ovf;
`endif

  modport slave (
    input  in_data, in_cin, in_valid,
    output in_ready,
    output op_a, op_b, op_cin, op_en,
    input  sum_in, cout_in,
    output res, res_cout, res_valid,
`ifdef OPSEQ_OVF_DETECT_EN
    output res_ovf,
`endif
    input  res_ready
  );

  modport master (
    output in_data, in_cin, in_valid,
    input  in_ready,
    input  op_a, op_b, op_cin, op_en,
    output sum_in, cout_in,
    input  res, res_cout, res_valid,
`ifdef OPSEQ_OVF_DETECT_EN
    input  res_ovf,
`endif
    output res_ready
  );
endinterface

// File: rtl/operand_sequencer.sv
// Loads A then B (+cin) over one bus, pulses the adder, holds the result.
// Ports: clk, rst_n (async low), bus (slave); OPSEQ_OVF_DETECT_EN adds res_ovf.
module operand_sequencer #(
  parameter int SIZE = 16
) (
  input logic             clk,
  input logic             rst_n,
  operand_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;
  logic   a_ld;
  logic   b_ld;
  logic   r_ld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_A;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    a_ld     = 1'b0;
    b_ld     = 1'b0;
    r_ld     = 1'b0;
    unique case (state)
      LOAD_A: begin
        if (bus.in_valid) begin
          a_ld     = 1'b1;
          state_nx = LOAD_B;
        end
      end
      LOAD_B: begin
        if (bus.in_valid) begin
          b_ld     = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC: begin
        r_ld     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        if (bus.res_ready) begin
          state_nx = LOAD_A;
        end
      end
      default: state_nx = LOAD_A;
    endcase
  end

  // Handshake flags decode straight from the state register, so they
  // are glitch-free and follow reset with the state.
  assign bus.in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign bus.op_en     = (state == EXEC);
  assign bus.res_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.op_a   <= '0;
      bus.op_b   <= '0;
      bus.op_cin <= 1'b0;
    end else begin
      if (a_ld) begin
        bus.op_a <= bus.in_data;
      end
      if (b_ld) begin
        bus.op_b   <= bus.in_data;
        bus.op_cin <= bus.in_cin;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.res      <= '0;
      bus.res_cout <= 1'b0;
    end else if (r_ld) begin
      bus.res      <= bus.sum_in;
      bus.res_cout <= bus.cout_in;
    end
  end

`ifdef OPSEQ_OVF_DETECT_EN
  // Signed overflow: like-signed operands giving a differently signed sum.
  logic ovf_nx;
  assign ovf_nx =
    (bus.op_a[SIZE-1] == bus.op_b[SIZE-1]) &&
    (bus.sum_in[SIZE-1] != bus.op_a[SIZE-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.res_ovf <= 1'b0;
    end else if (r_ld) begin
      bus.res_ovf <= ovf_nx;
    end
  end
`endif

endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench for operand_sequencer with a behavioural adder.
// Ports: drives the interface master side; checks res_ovf under OPSEQ_OVF_DETECT_EN.
module tb_operand_sequencer;

  logic clk;
  logic rst_n;

  operand_sequencer_if #(.SIZE(16)) bus ();

  operand_sequencer #(.SIZE(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  assign {bus.cout_in, bus.sum_in} =
    {1'b0, bus.op_a} + {1'b0, bus.op_b} + {16'd0, bus.op_cin};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [15:0] res;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec;
  int   n_err;
  int   cyc;
  int   en_cnt;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.op_en === 1'b1) en_cnt++;
  end

  // Result side of the scoreboard: pop on each result handshake.
  always @(negedge clk) begin
    if (rst_n && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_extra: res=%h with no expected entry", bus.res);
      end else begin
        mon_e = sb.pop_front();
        if ({bus.res, bus.res_cout} !== {mon_e.res, mon_e.cout}) begin
          n_err++;
          $display("FAIL sb_res: got %h/%b want %h/%b",
                   bus.res, bus.res_cout, mon_e.res, mon_e.cout);
        end
`ifdef OPSEQ_OVF_DETECT_EN
        n_vec++;
        if (bus.res_ovf !== mon_e.ovf) begin
          n_err++;
          $display("FAIL sb_ovf: got %b want %b", bus.res_ovf, mon_e.ovf);
        end
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string what);
    int k;
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s: in_ready got %b want 1 (timeout)", what, bus.in_ready);
    end
  endtask

  task automatic send_op(input logic [15:0] a, input logic [15:0] b,
                         input logic ca, input logic cb, output int t_a);
    logic [16:0] full;
    exp_t        e;
    bus.in_valid = 1'b1;
    bus.in_data  = a;
    bus.in_cin   = ca;
    wait_ready("a_beat");
    tick();
    t_a = cyc;
    bus.in_data = b;
    bus.in_cin  = cb;
    wait_ready("b_beat");
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_cin   = 1'b0;
    full   = {1'b0, a} + {1'b0, b} + {16'd0, cb};
    e.res  = full[15:0];
    e.cout = full[16];
    e.ovf  = (a[15] == b[15]) && (full[15] != a[15]);
    sb.push_back(e);
    n_vec++;
    if ({bus.op_en, bus.res_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL exec_flags: en/valid got %b want 10",
               {bus.op_en, bus.res_valid});
    end
    n_vec++;
    if ({bus.op_a, bus.op_b, bus.op_cin} !== {a, b, cb}) begin
      n_err++;
      $display("FAIL exec_ops: got %h %h %b want %h %h %b",
               bus.op_a, bus.op_b, bus.op_cin, a, b, cb);
    end
    tick();
    n_vec++;
    if ({bus.op_en, bus.res_valid} !== 2'b01) begin
      n_err++;
      $display("FAIL done_flags: en/valid got %b want 01",
               {bus.op_en, bus.res_valid});
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_data   = '0;
    bus.in_cin    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    #23;
    n_vec++;
    if ({bus.in_ready, bus.op_en, bus.res_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 100",
               {bus.in_ready, bus.op_en, bus.res_valid});
    end
    n_vec++;
    if ({bus.op_a, bus.op_b, bus.op_cin, bus.res, bus.res_cout} !== 50'd0) begin
      n_err++;
      $display("FAIL reset_regs: a=%h b=%h res=%h want 0",
               bus.op_a, bus.op_b, bus.res);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int t;
    send_op(16'h1234, 16'h0FF0, 1'b0, 1'b0, t);
    n_vec++;
    if (bus.res !== 16'h2224 || bus.res_cout !== 1'b0) begin
      n_err++;
      $display("FAIL basic_res: got %h/%b want 2224/0", bus.res, bus.res_cout);
    end
    tick();
  endtask

  task automatic test_carry();
    int t;
    int en0;
    en0 = en_cnt;
    send_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, t);
    tick();
    tick();
    n_vec++;
    if (en_cnt - en0 !== 1) begin
      n_err++;
      $display("FAIL op_en_pulse: got %0d cycles want 1", en_cnt - en0);
    end
  endtask

  task automatic test_cin();
    int t;
    send_op(16'hFFFF, 16'h0000, 1'b0, 1'b1, t);
    tick();
    send_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, t);
    n_vec++;
    if (bus.res !== 16'hFFFF || bus.res_cout !== 1'b0) begin
      n_err++;
      $display("FAIL cin_on_a: got %h/%b want ffff/0", bus.res, bus.res_cout);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int t;
    bus.res_ready = 1'b0;
    send_op(16'h1111, 16'h2222, 1'b0, 1'b0, t);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hABCD;
      tick();
      n_vec++;
      if ({bus.in_ready, bus.res_valid} !== 2'b01 || bus.res !== 16'h3333 ||
          bus.op_a !== 16'h1111 || bus.op_b !== 16'h2222) begin
        n_err++;
        $display("FAIL bp_hold%0d: rdy/vld=%b res=%h a=%h b=%h want 01 3333 1111 2222",
                 i, {bus.in_ready, bus.res_valid}, bus.res, bus.op_a, bus.op_b);
      end
    end
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    n_vec++;
    if ({bus.in_ready, bus.res_valid} !== 2'b10 || bus.res !== 16'h3333) begin
      n_err++;
      $display("FAIL bp_release: rdy/vld=%b res=%h want 10 3333",
               {bus.in_ready, bus.res_valid}, bus.res);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h5555;
    wait_ready("mid_a");
    tick();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.in_ready, bus.op_en, bus.res_valid} !== 3'b100 ||
        {bus.op_a, bus.op_b, bus.res, bus.res_cout} !== 49'd0) begin
      n_err++;
      $display("FAIL mid_reset: flags=%b a=%h res=%h want 100 0 0",
               {bus.in_ready, bus.op_en, bus.res_valid}, bus.op_a, bus.res);
    end
    tick();
    rst_n = 1'b1;
    send_op(16'h0003, 16'h0004, 1'b0, 1'b0, t);
    n_vec++;
    if (bus.res !== 16'h0007) begin
      n_err++;
      $display("FAIL mid_after: res got %h want 0007", bus.res);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int t;
    int tp;
    tp = 0;
    for (int i = 0; i < 6; i++) begin
      send_op(16'($urandom), 16'($urandom), 1'b0, 1'($urandom), t);
      if (i > 0) begin
        n_vec++;
        if (t - tp !== 4) begin
          n_err++;
          $display("FAIL b2b_rate%0d: got %0d cycles want 4", i, t - tp);
        end
      end
      tp = t;
    end
    tick();
  endtask

`ifdef OPSEQ_OVF_DETECT_EN
  task automatic test_ovf();
    int t;
    send_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, t);
    n_vec++;
    if (bus.res !== 16'h8000 || bus.res_ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_pos: got %h/%b want 8000/1", bus.res, bus.res_ovf);
    end
    tick();
    send_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, t);
    n_vec++;
    if (bus.res_ovf !== 1'b0 || bus.res_cout !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_neg: ovf/cout got %b/%b want 0/1",
               bus.res_ovf, bus.res_cout);
    end
    tick();
  endtask
`endif

  initial begin
    n_vec  = 0;
    n_err  = 0;
    cyc    = 0;
    en_cnt = 0;
    test_reset();
    test_basic();
    test_carry();
    test_cin();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef OPSEQ_OVF_DETECT_EN
    test_ovf();
`endif
    repeat (3) tick();
    n_vec++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d results outstanding want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
